// File: rtl/i2c_reg_write_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_reg_write_sequencer
//
// Walks an external register table from index 0 to stop_index-1 and issues one
// single-byte I2C register write per entry: START, {addr,W}, reg, data, STOP.
// Single master, write only, 7-bit addressing, open-drain bus.
//
// Ports
//   clk             system clock (rising edge)
//   reset_n         asynchronous active-low reset; releases both bus lines at once
//   start           one-cycle request to run the sequence (ignored while not idle)
//   busy            high while a sequence is in progress
//   done            one-cycle pulse when a sequence ends (with or without NACK)
//   nack_error      sticky NACK flag, cleared when the next start is accepted
//   stop_index      number of table entries to write
//   index           current table index, drives the external lookup table
//   i2c_address     7-bit slave address
//   i2c_reg_address register address for the current index
//   i2c_data        data byte for the current index
//   i2c_sda         open-drain SDA (driven 0 or Z)
//   i2c_scl         open-drain SCL (driven 0 or Z)
// -----------------------------------------------------------------------------
module i2c_reg_write_sequencer #(
   parameter int CLK_FREQ = 50000000,
   parameter int I2C_FREQ = 100000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       nack_error,
   input  logic [9:0] stop_index,
   output logic [9:0] index,
   input  logic [6:0] i2c_address,
   input  logic [7:0] i2c_reg_address,
   input  logic [7:0] i2c_data,
   inout  wire        i2c_sda,
   inout  wire        i2c_scl
);

   // clock cycles per quarter of an SCL period
   localparam int QTICK = CLK_FREQ / (4 * I2C_FREQ);
   localparam int QW    = (QTICK > 1) ? $clog2(QTICK) : 1;
   localparam logic [QW-1:0] QLAST = QW'(QTICK - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_BITS,
      S_STOP,
      S_FINISH
   } state_t;

   state_t        state_reg, state_next;
   logic [QW-1:0] qcnt_reg, qcnt_next;
   logic [1:0]    phase_reg, phase_next;     // quarter within the current bit
   logic [4:0]    bitcnt_reg, bitcnt_next;   // 0..26 across the three bytes
   logic [3:0]    slot_reg, slot_next;       // 0..7 data bit, 8 = ACK slot
   logic [23:0]   shreg_reg, shreg_next;
   logic [9:0]    index_reg, index_next;
   logic [9:0]    stop_reg, stop_next;
   logic          nack_reg, nack_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          sda_low_reg, scl_low_reg;
   logic [1:0]    drive_next;

   logic tick;
   logic hold;
   logic quarter_end;

   // Bus drive is decoded from the next-state values and registered, so the
   // open-drain enables never glitch and reset releases them immediately.
   function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] ph,
                                            input logic [3:0] sl, input logic b);
      logic sda_low;
      logic scl_low;
      sda_low = 1'b0;
      scl_low = 1'b0;
      case (st)
         S_START: begin
            sda_low = 1'b1;
            scl_low = (ph == 2'd1);
         end
         S_BITS: begin
            scl_low = (ph == 2'd0) || (ph == 2'd3);
            sda_low = (sl != 4'd8) && !b;
         end
         S_STOP: begin
            sda_low = (ph == 2'd0) || (ph == 2'd1);
            scl_low = (ph == 2'd0);
         end
         default: ;
      endcase
      return {sda_low, scl_low};
   endfunction

   assign tick = (qcnt_reg == QLAST);
   // Clock stretching: the raw line is sampled directly so that every cycle
   // the slave holds SCL low costs exactly one cycle.
   assign hold        = (state_reg == S_BITS) && (phase_reg == 2'd1) && (i2c_scl == 1'b0);
   assign quarter_end = tick && !hold;

   always_comb begin
      state_next  = state_reg;
      qcnt_next   = '0;
      phase_next  = phase_reg;
      bitcnt_next = bitcnt_reg;
      slot_next   = slot_reg;
      shreg_next  = shreg_reg;
      index_next  = index_reg;
      stop_next   = stop_reg;
      nack_next   = nack_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;

      if ((state_reg == S_START) || (state_reg == S_BITS) || (state_reg == S_STOP)) begin
         if (hold)
            qcnt_next = qcnt_reg;
         else if (!tick)
            qcnt_next = qcnt_reg + 1'b1;
      end

      case (state_reg)
         S_IDLE: begin
            index_next = '0;
            if (start) begin
               stop_next  = stop_index;
               nack_next  = 1'b0;
               busy_next  = 1'b1;
               state_next = (stop_index == 10'd0) ? S_FINISH : S_LOAD;
            end
         end

         S_LOAD: begin
            shreg_next = {i2c_address, 1'b0, i2c_reg_address, i2c_data};
            phase_next = 2'd0;
            state_next = S_START;
         end

         S_START: begin
            if (quarter_end) begin
               if (phase_reg == 2'd1) begin
                  phase_next  = 2'd0;
                  bitcnt_next = '0;
                  slot_next   = '0;
                  state_next  = S_BITS;
               end else begin
                  phase_next = phase_reg + 1'b1;
               end
            end
         end

         S_BITS: begin
            if (quarter_end) begin
               // Pulled-up SDA during the ACK slot means the slave did not ACK.
               if ((phase_reg == 2'd2) && (slot_reg == 4'd8) && (i2c_sda == 1'b1))
                  nack_next = 1'b1;
               if (phase_reg == 2'd3) begin
                  phase_next = 2'd0;
                  if (slot_reg != 4'd8) begin
                     shreg_next  = {shreg_reg[22:0], 1'b0};
                     slot_next   = slot_reg + 1'b1;
                     bitcnt_next = bitcnt_reg + 1'b1;
                  end else if (nack_reg || (bitcnt_reg == 5'd26)) begin
                     state_next = S_STOP;
                  end else begin
                     slot_next   = '0;
                     bitcnt_next = bitcnt_reg + 1'b1;
                  end
               end else begin
                  phase_next = phase_reg + 1'b1;
               end
            end
         end

         S_STOP: begin
            if (quarter_end) begin
               if (phase_reg == 2'd3) begin
                  phase_next = 2'd0;
                  if (!nack_reg && (({1'b0, index_reg} + 11'd1) < {1'b0, stop_reg})) begin
                     index_next = index_reg + 1'b1;
                     state_next = S_LOAD;
                  end else begin
                     state_next = S_FINISH;
                  end
               end else begin
                  phase_next = phase_reg + 1'b1;
               end
            end
         end

         S_FINISH: begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            index_next = '0;
            state_next = S_IDLE;
         end

         default: state_next = S_IDLE;
      endcase

      drive_next = bus_drive(state_next, phase_next, slot_next, shreg_next[23]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_IDLE;
         qcnt_reg    <= '0;
         phase_reg   <= '0;
         bitcnt_reg  <= '0;
         slot_reg    <= '0;
         shreg_reg   <= '0;
         index_reg   <= '0;
         stop_reg    <= '0;
         nack_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         sda_low_reg <= 1'b0;
         scl_low_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         qcnt_reg    <= qcnt_next;
         phase_reg   <= phase_next;
         bitcnt_reg  <= bitcnt_next;
         slot_reg    <= slot_next;
         shreg_reg   <= shreg_next;
         index_reg   <= index_next;
         stop_reg    <= stop_next;
         nack_reg    <= nack_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         sda_low_reg <= drive_next[1];
         scl_low_reg <= drive_next[0];
      end
   end

   assign i2c_sda    = sda_low_reg ? 1'b0 : 1'bz;
   assign i2c_scl    = scl_low_reg ? 1'b0 : 1'bz;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign nack_error = nack_reg;
   assign index      = index_reg;

endmodule

// File: tb/tb_i2c_reg_write_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for i2c_reg_write_sequencer.
// Stimulus pushes expected bus writes and expected done events into queues;
// a bus monitor / slave model and a done monitor pop and compare them.
// Reduced clock ratio: QTICK = 10, one write = 114*10 + 1 = 1141 cycles.
// -----------------------------------------------------------------------------
module tb_i2c_reg_write_sequencer;

   localparam int CLK_FREQ = 400000;
   localparam int I2C_FREQ = 10000;
   localparam int QT       = 10;
   localparam int W        = 114 * QT + 1;

   typedef struct {
      int          nb;
      logic [23:0] val;
   } wr_t;

   typedef struct {
      int   lat;
      logic nack;
   } dn_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] stop_index = '0;
   logic       busy;
   logic       done;
   logic       nack_error;
   logic [9:0] index;
   logic [6:0] i2c_address = 7'h5A;
   logic [7:0] i2c_reg_address;
   logic [7:0] i2c_data;
   wire        sda_w;
   wire        scl_w;

   logic [7:0] lut_reg [4];
   logic [7:0] lut_dat [4];

   logic slave_sda_low = 1'b0;
   logic slave_scl_low = 1'b0;

   pullup (sda_w);
   pullup (scl_w);
   assign sda_w = slave_sda_low ? 1'b0 : 1'bz;
   assign scl_w = slave_scl_low ? 1'b0 : 1'bz;

   assign i2c_reg_address = lut_reg[index[1:0]];
   assign i2c_data        = lut_dat[index[1:0]];

   i2c_reg_write_sequencer #(
      .CLK_FREQ(CLK_FREQ),
      .I2C_FREQ(I2C_FREQ)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .nack_error     (nack_error),
      .stop_index     (stop_index),
      .index          (index),
      .i2c_address    (i2c_address),
      .i2c_reg_address(i2c_reg_address),
      .i2c_data       (i2c_data),
      .i2c_sda        (sda_w),
      .i2c_scl        (scl_w)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int start_cyc = 0;
   int done_count = 0;

   wr_t exp_wr_q[$];
   dn_t exp_dn_q[$];

   // slave / monitor configuration
   int nack_wr   = -1;
   int nack_byte = -1;
   int stretch_wr = -1;

   // monitor state
   logic        prev_sda = 1'b1;
   logic        prev_scl = 1'b1;
   logic        mon_in_xfer = 1'b0;
   int          mon_bitcnt = 0;
   int          mon_nbytes = 0;
   logic [7:0]  mon_byte = '0;
   logic [23:0] mon_val = '0;
   int          write_idx = 0;
   int          starts_seen = 0;
   int          scl_rises = 0;
   int          stretch_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bus monitor and slave model: decodes START/STOP/bits, drives ACKs,
   // optionally NACKs one byte or stretches SCL on one address-byte ACK.
   always @(negedge clk) begin
      if (!reset_n) begin
         mon_in_xfer   = 1'b0;
         mon_bitcnt    = 0;
         mon_nbytes    = 0;
         slave_sda_low = 1'b0;
         slave_scl_low = 1'b0;
         stretch_cnt   = 0;
         prev_sda      = 1'b1;
         prev_scl      = 1'b1;
      end else begin
         if (stretch_cnt > 0) begin
            stretch_cnt--;
            if (stretch_cnt == 0) slave_scl_low = 1'b0;
         end
         if (prev_scl && scl_w && prev_sda && !sda_w) begin
            mon_in_xfer = 1'b1;
            mon_bitcnt  = 0;
            mon_nbytes  = 0;
            mon_val     = '0;
            write_idx   = starts_seen;
            starts_seen++;
         end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
            if (mon_in_xfer) begin
               $display("write %0d: %0d bytes %06h at cycle %0d", write_idx, mon_nbytes, mon_val, cyc);
               if (exp_wr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got %06h (%0d bytes), expected none", mon_val, mon_nbytes);
               end else begin
                  wr_t e;
                  e = exp_wr_q.pop_front();
                  check("write_nbytes", mon_nbytes, e.nb);
                  check("write_bytes", mon_val, e.val);
               end
            end
            mon_in_xfer = 1'b0;
         end else if (!prev_scl && scl_w) begin
            scl_rises++;
            if (mon_in_xfer) begin
               if (mon_bitcnt < 8) mon_byte = {mon_byte[6:0], sda_w};
               mon_bitcnt++;
               if (mon_bitcnt == 9) begin
                  case (mon_nbytes)
                     0: mon_val[23:16] = mon_byte;
                     1: mon_val[15:8]  = mon_byte;
                     default: mon_val[7:0] = mon_byte;
                  endcase
                  mon_nbytes++;
                  mon_bitcnt = 0;
               end
            end
         end else if (prev_scl && !scl_w) begin
            if (slave_sda_low) begin
               slave_sda_low = 1'b0;
            end else if (mon_in_xfer && mon_bitcnt == 8) begin
               if (!(write_idx == nack_wr && mon_nbytes == nack_byte)) slave_sda_low = 1'b1;
               if (write_idx == stretch_wr && mon_nbytes == 0) begin
                  // held from bit-7 Q3: two quarters until the ACK's Q1, then 300 more
                  slave_scl_low = 1'b1;
                  stretch_cnt   = 2 * QT + 300;
               end
            end
         end
         prev_sda = sda_w;
         prev_scl = scl_w;
      end
   end

   // Done monitor
   always @(negedge clk) begin
      if (reset_n && done) begin
         done_count++;
         $display("done at cycle %0d: latency %0d nack_error %0b", cyc, cyc - start_cyc, nack_error);
         if (exp_dn_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            dn_t e;
            e = exp_dn_q.pop_front();
            check("done_latency", cyc - start_cyc, e.lat);
            check("done_nack_error", {31'b0, nack_error}, {31'b0, e.nack});
            check("done_busy", {31'b0, busy}, 32'd0);
            check("done_index", {22'b0, index}, 32'd0);
         end
      end
   end

   task automatic push_wr(input int nb, input logic [23:0] v);
      wr_t e;
      e.nb  = nb;
      e.val = v;
      exp_wr_q.push_back(e);
   endtask

   task automatic push_dn(input int lat, input logic nk);
      dn_t e;
      e.lat  = lat;
      e.nack = nk;
      exp_dn_q.push_back(e);
   endtask

   task automatic do_start(input logic [9:0] si);
      @(posedge clk);
      #1;
      stop_index = si;
      start      = 1'b1;
      start_cyc  = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n;
      n = 0;
      while (done_count == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_count == d0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", budget);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #(400000 * 10);
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int rises0;
      int n;

      lut_reg[0] = 8'h10; lut_dat[0] = 8'hA1;
      lut_reg[1] = 8'h11; lut_dat[1] = 8'hB2;
      lut_reg[2] = 8'h12; lut_dat[2] = 8'hC3;
      lut_reg[3] = 8'h13; lut_dat[3] = 8'hD4;

      // ---------------- reset values ----------------
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_nack_error", {31'b0, nack_error}, 32'd0);
      check("reset_index", {22'b0, index}, 32'd0);
      check("reset_sda", {31'b0, sda_w}, 32'd1);
      check("reset_scl", {31'b0, scl_w}, 32'd1);

      // ---------------- three-entry sequence ----------------
      push_wr(3, 24'hB410A1);
      push_wr(3, 24'hB411B2);
      push_wr(3, 24'hB412C3);
      push_dn(3 * W + 2, 1'b0);
      d0 = done_count;
      do_start(10'd3);
      check("start_busy", {31'b0, busy}, 32'd1);
      wait_done(d0, 3 * W + 100);
      check("three_writes_drained", exp_wr_q.size(), 32'd0);

      // ---------------- NACK on register byte of index 1 ----------------
      nack_wr   = starts_seen + 1;
      nack_byte = 1;
      push_wr(3, 24'hB410A1);
      push_wr(2, 24'hB41100);
      push_dn(W + (1 + 78 * QT) + 2, 1'b1);
      d0 = done_count;
      do_start(10'd3);
      wait_done(d0, 3 * W + 100);
      nack_wr = -1;
      check("nack_sticky", {31'b0, nack_error}, 32'd1);

      // ---------------- zero-length sequence, clears nack_error ----------------
      rises0 = scl_rises;
      push_dn(2, 1'b0);
      d0 = done_count;
      do_start(10'd0);
      check("zero_busy", {31'b0, busy}, 32'd1);
      check("zero_nack_cleared", {31'b0, nack_error}, 32'd0);
      wait_done(d0, 50);
      check("zero_no_scl_edges", scl_rises, rises0);

      // ---------------- clock stretch on address-byte ACK ----------------
      stretch_wr = starts_seen;
      push_wr(3, 24'hB410A1);
      push_dn(W + 300 + 2, 1'b0);
      d0 = done_count;
      do_start(10'd1);
      wait_done(d0, W + 500);
      stretch_wr = -1;

      // ---------------- start while busy and in FINISH cycle ----------------
      push_wr(3, 24'hB410A1);
      push_wr(3, 24'hB411B2);
      push_dn(2 * W + 2, 1'b0);
      d0 = done_count;
      do_start(10'd2);
      repeat (100) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (cyc < start_cyc + 2 * W + 1 && n < 3 * W) begin
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b1;            // held during the FINISH cycle
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0, 3 * W);
      repeat (50) @(posedge clk);
      #1;
      check("busy_after_ignored_starts", {31'b0, busy}, 32'd0);
      check("one_done_only", done_count, d0 + 1);

      // ---------------- reset mid-transfer (bit 5 of reg byte) ----------------
      d0 = done_count;
      do_start(10'd3);
      n = 0;
      while (!(mon_in_xfer && mon_nbytes == 1 && mon_bitcnt == 5) && n < 2 * W) begin
         @(posedge clk);
         n++;
      end
      check("reached_reg_bit5", {31'b0, (mon_nbytes == 1 && mon_bitcnt == 5)}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_sda_released", {31'b0, sda_w}, 32'd1);
      check("rst_scl_released", {31'b0, scl_w}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_index", {22'b0, index}, 32'd0);
      rises0 = scl_rises;
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      check("rst_no_scl_edges", scl_rises, rises0);
      check("rst_no_done", done_count, d0);
      check("rst_busy_stays_low", {31'b0, busy}, 32'd0);

      // ---------------- scoreboard drained ----------------
      check("write_queue_empty", exp_wr_q.size(), 32'd0);
      check("done_queue_empty", exp_dn_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_reg_write_sequencer.md
# i2c_reg_write_sequencer

Register-write engine directly downstream of the I2C configuration wrapper. It takes a device address, a stop index and a per-index register/data pair supplied by an external lookup table. It walks the table from index 0 and performs one single-byte I2C register write per entry on the open-drain bus. It is a single-master, write-only, 7-bit-addressing engine.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- I2C_FREQ, 100000, SCL frequency in Hz. QTICK = CLK_FREQ/(4*I2C_FREQ) clock cycles per quarter-bit (125 at defaults).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run the sequence; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until the sequence ends.
- done  out  1  one-cycle pulse when a sequence ends, with or without error.
- nack_error  out  1  sticky flag, set on any NACK; cleared when the next start is accepted.
- stop_index  in  10  number of table entries to write (indices 0..stop_index-1).
- index  out  10  current table index, driven to the LUT.
- i2c_address  in  7  slave address.
- i2c_reg_address  in  8  register address for the current index.
- i2c_data  in  8  data byte for the current index.
- i2c_sda  inout  1  open-drain; driven 0 or Z only.
- i2c_scl  inout  1  open-drain; driven 0 or Z only.

## Operation
- **IDLE:** both lines at Z; index=0; busy=0.
- **Accepting start:** start=1 in IDLE →
  - latch stop_index; clear nack_error; set busy.
  - If latched stop_index=0, go to FINISH. Otherwise go to LOAD.
- **LOAD** (1 cycle, entered one cycle after index changes): capture i2c_address, i2c_reg_address and i2c_data into a 24-bit shift register as {addr, 1'b0 (W), reg, data}.
- **START:** two quarters.
  - Q_A: SDA=0, SCL=Z.
  - Q_B: SCL=0.
- **BITS:** 27 bits (3 bytes × (8 data bits + ACK)), MSB first, 4 quarters each.
  - Q0: SCL=0; SDA = data bit, or Z for the ACK slot.
  - Q1: SCL=Z. The quarter counter holds while sampled SCL is 0 (clock stretching).
  - Q2: SCL=Z. In the ACK slot, sample SDA; 1 means NACK.
  - Q3: SCL=0.
- **NACK:** set nack_error, finish the current ACK bit, then STOP, then FINISH. No further bytes or indices are written.
- **STOP:** four quarters.
  - Q0: SDA=0, SCL=0.
  - Q1: SCL=Z.
  - Q2: SDA=Z.
  - Q3: bus-free gap, both Z.
- **After STOP:** if there was no NACK and index+1 < stop_index, increment index and go to LOAD. Otherwise go to FINISH.
- **FINISH** (1 cycle): done=1, busy=0, index=0, return to IDLE.
- **Width rules:**
  - Quarter counter: ceil(log2(QTICK)) bits, wraps at QTICK-1.
  - Bit counter: 0..26.
  - index compare is unsigned 10-bit.

## Timing
- **Reset values:** busy=0, done=0, nack_error=0, index=0, SDA=Z, SCL=Z, state IDLE.
- **Reset assertion mid-transfer:** both lines are released asynchronously in the same instant. No STOP is generated.
- **Start latency:** busy=1 in the cycle after start is sampled. Simultaneous start and reset_n=0: reset wins.
- **Per-write duration without stretching:** (2 + 108 + 4) quarters × QTICK plus 1 LOAD cycle = 14251 cycles at defaults.
- **Index/LOAD relationship:** index changes one cycle before LOAD. The external LUT must settle combinationally within that cycle.
- **Stretching:** each clock cycle SCL is held low by the slave in Q1 adds exactly one cycle.
- **done:** asserts in the same cycle busy falls.
- **start while busy:** no effect, including in the FINISH cycle.

## Test plan
- **Reset:** reset_n pulsed low mid-transfer (bit 5 of the reg byte) → SDA/SCL both Z immediately, busy=0, index=0. No further SCL edges.
- **Three-entry sequence:** stop_index=3, address 7'h5A, LUT {0:(8'h10,8'hA1), 1:(8'h11,8'hB2), 2:(8'h12,8'hC3)}, model ACKs everything →
  - bus monitor decodes exactly three writes B4 10 A1, B4 11 B2, B4 12 C3;
  - done pulse at 3×14251+2 cycles after start;
  - nack_error=0.
- **NACK on register byte:** model NACKs the register byte of index 1 →
  - STOP follows immediately; index 2 is never written;
  - nack_error=1 with the done pulse.
  - A new start clears nack_error.
- **Clock stretch:** model holds SCL low 300 cycles on the ACK of the address byte → transaction takes 14551 cycles. Data is unchanged.
- **Zero-length sequence:** stop_index=0 → busy high for 1 cycle, done pulse, no bus activity.
- **Start while busy:** start pulsed while busy=1, and again in the FINISH cycle → ignored. Exactly one sequence executes.
